// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, sign classes and the (row,col)->key map shared by keypad_scanner and number_storage.
package keypad_pkg;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;
  typedef enum logic [2:0] {
    SIGN_DIGIT = 3'b000,
    SIGN_ENTER = 3'b001,
    SIGN_ADD   = 3'b010,
    SIGN_CLR   = 3'b011,
    SIGN_SUB   = 3'b100,
    SIGN_STAR  = 3'b101,
    SIGN_MUL   = 3'b111
  } sign_e;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_e;
  // Nibble {row,col} holds that key's code; row 0 col 0 is the LSB nibble.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col, 2'b00} +: 4];
  endfunction
  function automatic sign_e sign_of(input logic [3:0] key);
    case (key)
      KEY_HASH: return SIGN_ENTER;
      KEY_A:    return SIGN_ADD;
      KEY_B:    return SIGN_SUB;
      KEY_C:    return SIGN_CLR;
      KEY_STAR: return SIGN_STAR;
      KEY_D:    return SIGN_MUL;
      default:  return SIGN_DIGIT;
    endcase
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs; resets to all ones (idle keypad rows).
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '1;
      q_o  <= '1;
    end else begin
      s1_q <= d_i;
      q_o  <= s1_q;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with tick-based press/release debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 27000,
  parameter int DEB_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_value,
  output logic       key_pressed,
  output logic       key_valid,
  output logic [2:0] is_sign_key
);
  localparam int TW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_TICKS);
  logic [3:0] row_s;
  logic [TW-1:0] tick_q;
  logic tick, row_hit;
  logic [1:0] low_row;
  state_e state_q, state_d;
  logic [1:0] col_q, col_d, row_q, row_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [3:0] key_q, key_d, col_n_q;
  sign_e sign_q, sign_d;
  logic pressed_q, pressed_d, valid_q, valid_d;
  sync_2ff #(.W(4)) u_sync (.clk(clk), .rst(rst), .d_i(row_n), .q_o(row_s));
  assign tick    = tick_q == TICK_MAX;
  assign row_hit = !row_s[row_q];
  assign low_row = !row_s[0] ? 2'd0 : !row_s[1] ? 2'd1 : !row_s[2] ? 2'd2 : 2'd3;
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    deb_d     = deb_q;
    key_d     = key_q;
    sign_d    = sign_q;
    pressed_d = pressed_q;
    valid_d   = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (&row_s) col_d = col_q + 2'd1;
          else begin
            row_d   = low_row;
            deb_d   = DW'(1);
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (row_hit) begin
            deb_d = deb_q + 1'b1;
            if (deb_d >= DEB_MAX) begin
              state_d   = PRESSED;
              key_d     = key_code(row_q, col_q);
              sign_d    = sign_of(key_d);
              pressed_d = 1'b1;
              valid_d   = 1'b1;
            end
          end else begin
            deb_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end
        end
        PRESSED: begin
          if (!row_hit) begin
            deb_d   = DW'(1);
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (row_hit) state_d = PRESSED;
          else begin
            deb_d = deb_q + 1'b1;
            if (deb_d >= DEB_MAX) begin
              deb_d     = '0;
              pressed_d = 1'b0;
              col_d     = col_q + 2'd1;
              state_d   = SCAN;
            end
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q    <= '0;
      state_q   <= SCAN;
      col_q     <= '0;
      row_q     <= '0;
      deb_q     <= '0;
      key_q     <= '0;
      sign_q    <= SIGN_DIGIT;
      pressed_q <= 1'b0;
      valid_q   <= 1'b0;
      col_n_q   <= 4'b1110;
    end else begin
      tick_q    <= tick ? '0 : tick_q + 1'b1;
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      deb_q     <= deb_d;
      key_q     <= key_d;
      sign_q    <= sign_d;
      pressed_q <= pressed_d;
      valid_q   <= valid_d;
      col_n_q   <= ~(4'b0001 << col_d);
    end
  end
  assign col_n       = col_n_q;
  assign key_value   = key_q;
  assign key_pressed = pressed_q;
  assign key_valid   = valid_q;
  assign is_sign_key = sign_q;
endmodule
